nvram_xfer: RTL

- Bulk-transfer initiator for the 256x4 X2212-style NVRAM.
- Sits between the CPU-side NVRAM select logic and the NVRAM array, and owns the array's a/i/ce_n/rw_n pins.
- Dump mode: reads every nibble, packs pairs into bytes and streams them out to the host save path.
- Load mode: accepts a byte stream from the host and writes it back nibble by nibble.
- When idle, CPU accesses pass straight through to the array.

---
 rtl/nvram_xfer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/nvram_xfer.sv
// ============================================================================
// Module   : nvram_xfer
// Purpose  : Bulk dump/load initiator for a 256x4 X2212-style NVRAM; CPU
//            accesses pass straight through to the array while idle.
//            Optional trailing XOR checksum byte: NVRAM_XFER_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nvram_xfer #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] cpu_a,
    input  logic [3:0]    cpu_i,
    input  logic          cpu_ce_n,
    input  logic          cpu_rw_n,
    output logic [AW-1:0] nv_a,
    output logic [3:0]    nv_i,
    output logic          nv_ce_n,
    output logic          nv_rw_n,
    input  logic [3:0]    nv_o,
    input  logic          dump_start,
    input  logic          load_start,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready
);

`ifdef NVRAM_XFER_CHECKSUM_EN
    localparam logic c_CKS_EN = 1'b1;
`else
    localparam logic c_CKS_EN = 1'b0;
`endif

    localparam int c_KW = AW - 1;

    localparam logic [3:0] c_S_IDLE = 4'd0;
    localparam logic [3:0] c_S_RD0  = 4'd1;
    localparam logic [3:0] c_S_RD1  = 4'd2;
    localparam logic [3:0] c_S_RDW  = 4'd3;
    localparam logic [3:0] c_S_TX   = 4'd4;
    localparam logic [3:0] c_S_RX   = 4'd5;
    localparam logic [3:0] c_S_WR0  = 4'd6;
    localparam logic [3:0] c_S_WR1  = 4'd7;
    localparam logic [3:0] c_S_FIN  = 4'd8;

    logic [3:0]      r_state;
    logic [c_KW-1:0] r_idx;
    logic [3:0]      r_lo;
    logic [7:0]      r_tx_data;
    logic [7:0]      r_rx_byte;
    logic [7:0]      r_csum;
    logic            r_cks_phase;
    logic            r_err;

    logic            w_last;
    logic            w_tx_hs;
    logic            w_rx_hs;

    assign w_last  = &r_idx;
    assign w_tx_hs = (r_state == c_S_TX) && tx_ready;
    assign w_rx_hs = (r_state == c_S_RX) && rx_valid;

    assign busy     = (r_state != c_S_IDLE);
    assign done     = (r_state == c_S_FIN);
    assign tx_valid = (r_state == c_S_TX);
    assign rx_ready = (r_state == c_S_RX);
    assign tx_data  = r_tx_data;
    assign err      = c_CKS_EN ? r_err : 1'b0;

    // Array pin ownership: CPU while idle, controller otherwise.
    always_comb begin
        nv_a    = cpu_a;
        nv_i    = cpu_i;
        nv_ce_n = cpu_ce_n;
        nv_rw_n = cpu_rw_n;
        if (r_state != c_S_IDLE) begin
            nv_a    = {r_idx, 1'b0};
            nv_i    = r_rx_byte[3:0];
            nv_ce_n = 1'b1;
            nv_rw_n = 1'b1;
            case (r_state)
                c_S_RD0: begin
                    nv_ce_n = 1'b0;
                end
                c_S_RD1: begin
                    nv_a    = {r_idx, 1'b1};
                    nv_ce_n = 1'b0;
                end
                c_S_WR0: begin
                    nv_ce_n = 1'b0;
                    nv_rw_n = 1'b0;
                end
                c_S_WR1: begin
                    nv_a    = {r_idx, 1'b1};
                    nv_i    = r_rx_byte[7:4];
                    nv_ce_n = 1'b0;
                    nv_rw_n = 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_S_IDLE;
            r_idx       <= '0;
            r_lo        <= 4'h0;
            r_tx_data   <= 8'h00;
            r_rx_byte   <= 8'h00;
            r_csum      <= 8'h00;
            r_cks_phase <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (dump_start || load_start) begin
                        r_idx       <= '0;
                        r_csum      <= 8'h00;
                        r_cks_phase <= 1'b0;
                        r_err       <= 1'b0;
                        r_state     <= dump_start ? c_S_RD0 : c_S_RX;
                    end
                end
                c_S_RD0: begin
                    r_state <= c_S_RD1;
                end
                // Array read data lags the address by one cycle.
                c_S_RD1: begin
                    r_lo    <= nv_o;
                    r_state <= c_S_RDW;
                end
                c_S_RDW: begin
                    r_tx_data <= {nv_o, r_lo};
                    r_csum    <= r_csum ^ {nv_o, r_lo};
                    r_state   <= c_S_TX;
                end
                c_S_TX: begin
                    if (w_tx_hs) begin
                        if (r_cks_phase) begin
                            r_state <= c_S_FIN;
                        end else if (!w_last) begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= c_S_RD0;
                        end else if (c_CKS_EN) begin
                            r_cks_phase <= 1'b1;
                            r_tx_data   <= r_csum;
                        end else begin
                            r_state <= c_S_FIN;
                        end
                    end
                end
                c_S_RX: begin
                    if (w_rx_hs) begin
                        if (r_cks_phase) begin
                            r_err   <= (rx_data != r_csum);
                            r_state <= c_S_FIN;
                        end else begin
                            r_rx_byte <= rx_data;
                            r_csum    <= r_csum ^ rx_data;
                            r_state   <= c_S_WR0;
                        end
                    end
                end
                c_S_WR0: begin
                    r_state <= c_S_WR1;
                end
                c_S_WR1: begin
                    if (!w_last) begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= c_S_RX;
                    end else if (c_CKS_EN) begin
                        r_cks_phase <= 1'b1;
                        r_state     <= c_S_RX;
                    end else begin
                        r_state <= c_S_FIN;
                    end
                end
                c_S_FIN: begin
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
